// File: rtl/audio_nios_pio_key.sv
// Avalon-MM parallel input port with synchronizers and edge capture.
// A masked edgecapture drives a level interrupt.
module audio_nios_pio_key #(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] interruptmask;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_next;
    logic [1:0]       arm_cnt;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             armed;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;
    assign wr_en = chipselect & ~write_n;
    assign armed = (arm_cnt == 2'd3);

    always_comb begin
        edge_raw = '0;
        case (EDGE_TYPE)
            0:       edge_raw = sync2 & ~prev;
            1:       edge_raw = ~sync2 & prev;
            default: edge_raw = sync2 ^ prev;
        endcase
        edge_det = armed ? edge_raw : '0;
    end

    // Set wins over a same-cycle write-1-to-clear.
    always_comb begin
        cap_next = edgecapture;
        if (wr_en && address == 2'd3) begin
            cap_next = edgecapture & ~writedata[WIDTH-1:0];
        end
        cap_next = cap_next | edge_det;
    end

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next[WIDTH-1:0] = sync2;
            2'd2:    rd_next[WIDTH-1:0] = interruptmask;
            2'd3:    rd_next[WIDTH-1:0] = edgecapture;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1         <= '0;
            sync2         <= '0;
            prev          <= '0;
            edgecapture   <= '0;
            interruptmask <= '0;
            readdata      <= '0;
            arm_cnt       <= '0;
        end else begin
            sync1       <= in_port;
            sync2       <= sync1;
            prev        <= sync2;
            edgecapture <= cap_next;
            readdata    <= rd_next;
            if (!armed) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
            if (wr_en && address == 2'd2) begin
                interruptmask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edgecapture & interruptmask);

endmodule

// File: tb/tb_audio_nios_pio_key.sv
// Directed vector bench for audio_nios_pio_key.
// A second instance covers rising-edge capture.
module tb_audio_nios_pio_key;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [3:0]  in_port2;
    logic [31:0] readdata;
    logic [31:0] readdata2;
    logic        irq;
    logic        irq2;

    int total;
    int passed;

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wr_n;
        logic [31:0] wd;
        logic [3:0]  inp;
        logic [31:0] rd;
        logic        irq;
    } vec_t;

    vec_t tbl[30];

    audio_nios_pio_key #(.WIDTH(4), .EDGE_TYPE(1)) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    audio_nios_pio_key #(.WIDTH(4), .EDGE_TYPE(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port2),
        .readdata(readdata2), .irq(irq2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic [1:0] a, input logic c,
                                input logic w, input logic [31:0] d,
                                input logic [3:0] i, input logic [31:0] r,
                                input logic q);
        vec_t v;
        v.addr = a; v.cs = c; v.wr_n = w; v.wd = d;
        v.inp = i; v.rd = r; v.irq = q;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        total = 0;
        passed = 0;
        reset_n = 1'b0;
        address = 2'd3;
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = '0;
        in_port = 4'hF;
        in_port2 = 4'hF;

        // in_port high through reset
        repeat (3) tick();
        check("reset_rd", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_rd2", readdata2, 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_cap", readdata, 32'h0);
            check("hold_cap_rise", readdata2, 32'h0);
        end

        //            addr  cs    wr_n  wd            in    rd         irq
        tbl[0]  = mk(2'd2, 1'b1, 1'b0, 32'hF,        4'hF, 32'h0, 1'b0);
        tbl[1]  = mk(2'd2, 1'b0, 1'b1, 32'h0,        4'hF, 32'hF, 1'b0);
        tbl[2]  = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hE, 32'h0, 1'b0);
        tbl[3]  = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hE, 32'h0, 1'b0);
        tbl[4]  = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hE, 32'h0, 1'b1);
        tbl[5]  = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hE, 32'h1, 1'b1);
        tbl[6]  = mk(2'd0, 1'b0, 1'b1, 32'h0,        4'hE, 32'hE, 1'b1);
        tbl[7]  = mk(2'd3, 1'b1, 1'b0, 32'h1,        4'hE, 32'h1, 1'b0);
        tbl[8]  = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hE, 32'h0, 1'b0);
        tbl[9]  = mk(2'd2, 1'b1, 1'b0, 32'h0,        4'hE, 32'hF, 1'b0);
        tbl[10] = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hA, 32'h0, 1'b0);
        tbl[11] = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hA, 32'h0, 1'b0);
        tbl[12] = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hA, 32'h0, 1'b0);
        tbl[13] = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hA, 32'h4, 1'b0);
        tbl[14] = mk(2'd2, 1'b1, 1'b0, 32'h4,        4'hA, 32'h0, 1'b1);
        tbl[15] = mk(2'd2, 1'b0, 1'b1, 32'h0,        4'hA, 32'h4, 1'b1);
        tbl[16] = mk(2'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 4'hA, 32'hA, 1'b1);
        tbl[17] = mk(2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 4'hA, 32'h0, 1'b1);
        tbl[18] = mk(2'd1, 1'b0, 1'b1, 32'h0,        4'hA, 32'h0, 1'b1);
        tbl[19] = mk(2'd2, 1'b0, 1'b1, 32'h0,        4'hA, 32'h4, 1'b1);
        tbl[20] = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hA, 32'h4, 1'b1);
        tbl[21] = mk(2'd0, 1'b0, 1'b1, 32'h0,        4'hA, 32'hA, 1'b1);
        tbl[22] = mk(2'd3, 1'b1, 1'b0, 32'hF,        4'hA, 32'h4, 1'b0);
        tbl[23] = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hB, 32'h0, 1'b0);
        tbl[24] = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hB, 32'h0, 1'b0);
        tbl[25] = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hB, 32'h0, 1'b0);
        tbl[26] = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hA, 32'h0, 1'b0);
        tbl[27] = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hA, 32'h0, 1'b0);
        tbl[28] = mk(2'd3, 1'b1, 1'b0, 32'h1,        4'hA, 32'h0, 1'b0);
        tbl[29] = mk(2'd3, 1'b0, 1'b1, 32'h0,        4'hA, 32'h1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            address = tbl[i].addr;
            chipselect = tbl[i].cs;
            write_n = tbl[i].wr_n;
            writedata = tbl[i].wd;
            in_port = tbl[i].inp;
            tick();
            check($sformatf("vec%0d_rd", i), readdata, tbl[i].rd);
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].irq});
        end

        // rising edge capture on the EDGE_TYPE=0 instance
        chipselect = 1'b0;
        write_n = 1'b1;
        address = 2'd3;
        in_port2 = 4'h0;
        repeat (4) tick();
        check("rise_none", readdata2, 32'h0);
        in_port2 = 4'h9;
        repeat (4) tick();
        check("rise_cap", readdata2, 32'h9);

        // mid-operation reset drops mask and pending edges
        address = 2'd2;
        chipselect = 1'b1;
        write_n = 1'b0;
        writedata = 32'hF;
        tick();
        chipselect = 1'b0;
        write_n = 1'b1;
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        check("mid_rst_irq2", {31'b0, irq2}, 32'h0);
        reset_n = 1'b1;
        tick();
        check("mid_rst_mask", readdata, 32'h0);
        address = 2'd3;
        tick();
        check("mid_rst_cap", readdata, 32'h0);
        check("mid_rst_cap2", readdata2, 32'h0);
        repeat (4) tick();
        check("rearm_cap2", readdata2, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
